// File: rtl/imem_arbiter_if.sv
// Bundle for the instruction-memory arbiter: fetch port, loader port and memory command/response.
// The arbiter uses the slave view; the requesters and the memory array use the master view.
interface imem_arbiter_if #(
  parameter int IDX_W = 16
);
  logic              f_req;
  logic [31:0]       f_addr;
  logic              f_gnt;
  logic              f_rvalid;
  logic [31:0]       f_rdata;
  logic              f_err;

  logic              l_req;
  logic              l_lock;
  logic [31:0]       l_addr;
  logic [31:0]       l_wdata;
  logic              l_gnt;
  logic              l_err;
  logic [15:0]       l_cnt;

  logic              m_en;
  logic              m_we;
  logic [IDX_W-1:0]  m_idx;
  logic [31:0]       m_wdata;
  logic [31:0]       m_rdata;

  modport slave (
    input  f_req, f_addr, l_req, l_lock, l_addr, l_wdata, m_rdata,
    output f_gnt, f_rvalid, f_rdata, f_err, l_gnt, l_err, l_cnt,
           m_en, m_we, m_idx, m_wdata
  );

  modport master (
    output f_req, f_addr, l_req, l_lock, l_addr, l_wdata, m_rdata,
    input  f_gnt, f_rvalid, f_rdata, f_err, l_gnt, l_err, l_cnt,
           m_en, m_we, m_idx, m_wdata
  );
endinterface

// File: rtl/imem_arbiter.sv
// Round-robin arbiter sharing a single-port instruction memory between the fetch port
// (reads) and the program loader (writes), with loader lock, address checks and a write counter.
module imem_arbiter #(
  parameter int DEPTH = 65536,
  parameter int IDX_W = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  imem_arbiter_if.slave   bus
);

  typedef enum logic {
    GNT_FETCH  = 1'b0,
    GNT_LOADER = 1'b1
  } owner_e;

  owner_e       last_q, last_d;
  logic         rvalid_q, rvalid_d;
  logic         ferr_q, ferr_d;
  logic [31:0]  rdata_q, rdata_d;
  logic [15:0]  cnt_q, cnt_d;

  logic         f_bad, l_bad;
  logic         f_gnt, l_gnt;
  logic         m_en, m_we;
  logic [IDX_W-1:0] m_idx;
  logic [31:0]  m_wdata;
  logic [31:0]  f_rdata;

  function automatic logic addr_bad(input logic [31:0] a);
    return (a[1:0] != 2'b00) || ({2'b00, a[31:2]} >= 32'(DEPTH));
  endfunction

  // Grants are gated by rst_n so every output reads zero while reset is held.
  always_comb begin
    f_bad = addr_bad(bus.f_addr);
    l_bad = addr_bad(bus.l_addr);
    f_gnt = 1'b0;
    l_gnt = 1'b0;
    if (rst_n) begin
      if (bus.l_lock) begin
        l_gnt = bus.l_req;
      end else if (bus.f_req && bus.l_req) begin
        f_gnt = (last_q == GNT_LOADER);
        l_gnt = (last_q == GNT_FETCH);
      end else begin
        f_gnt = bus.f_req;
        l_gnt = bus.l_req;
      end
    end
  end

  always_comb begin
    m_en    = 1'b0;
    m_we    = 1'b0;
    m_idx   = '0;
    m_wdata = '0;
    if (f_gnt && !f_bad) begin
      m_en  = 1'b1;
      m_idx = bus.f_addr[IDX_W+1:2];
    end else if (l_gnt && !l_bad) begin
      m_en    = 1'b1;
      m_we    = 1'b1;
      m_idx   = bus.l_addr[IDX_W+1:2];
      m_wdata = bus.l_wdata;
    end
  end

  // Response data comes straight from the memory in the response cycle and is held afterwards.
  always_comb begin
    if (rvalid_q) begin
      f_rdata = ferr_q ? 32'h0 : bus.m_rdata;
    end else begin
      f_rdata = rdata_q;
    end
  end

  always_comb begin
    last_d = last_q;
    if (!bus.l_lock) begin
      if (f_gnt) begin
        last_d = GNT_FETCH;
      end else if (l_gnt) begin
        last_d = GNT_LOADER;
      end
    end
    rvalid_d = f_gnt;
    ferr_d   = f_gnt && f_bad;
    rdata_d  = rvalid_q ? f_rdata : rdata_q;
    cnt_d    = cnt_q;
    if (l_gnt && !l_bad && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q   <= GNT_LOADER;
      rvalid_q <= 1'b0;
      ferr_q   <= 1'b0;
      rdata_q  <= 32'h0;
      cnt_q    <= 16'h0;
    end else begin
      last_q   <= last_d;
      rvalid_q <= rvalid_d;
      ferr_q   <= ferr_d;
      rdata_q  <= rdata_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.f_gnt    = f_gnt;
  assign bus.f_rvalid = rvalid_q;
  assign bus.f_rdata  = f_rdata;
  assign bus.f_err    = rvalid_q && ferr_q;
  assign bus.l_gnt    = l_gnt;
  assign bus.l_err    = l_gnt && l_bad;
  assign bus.l_cnt    = cnt_q;
  assign bus.m_en     = m_en;
  assign bus.m_we     = m_we;
  assign bus.m_idx    = m_idx;
  assign bus.m_wdata  = m_wdata;

endmodule

// File: tb/tb_imem_arbiter.sv
// Bench for imem_arbiter: vector table plus hand-written reset sequences, with a
// scoreboard queue of expected fetch responses and a 1-cycle synchronous memory model.
module tb_imem_arbiter;
  localparam int DEPTH = 65536;
  localparam int IDX_W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  imem_arbiter_if #(.IDX_W(IDX_W)) bus ();

  imem_arbiter #(.DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [31:0] mem     [DEPTH];
  logic [31:0] ref_mem [DEPTH];

  always @(posedge clk) begin
    if (bus.m_en) begin
      if (bus.m_we) mem[bus.m_idx] <= bus.m_wdata;
      else          bus.m_rdata    <= mem[bus.m_idx];
    end
  end

  typedef struct {
    string       name;
    logic        fr, lr, lk;
    logic [31:0] fa, la, lw;
    logic        efg, elg, emen, emwe, elerr;
  } vec_t;

  typedef struct {
    logic        err;
    logic [31:0] data;
  } rsp_t;

  vec_t        tbl[$];
  rsp_t        sb[$];
  int          n_chk = 0;
  int          n_fail = 0;
  logic [15:0] cnt_model = 16'h0;
  logic [31:0] exp_hold = 32'h0;

  function automatic vec_t mk(input string nm, input logic fr, lr, lk,
                              input logic [31:0] fa, la, lw,
                              input logic efg, elg, emen, emwe, elerr);
    vec_t v;
    v.name = nm; v.fr = fr; v.lr = lr; v.lk = lk;
    v.fa = fa; v.la = la; v.lw = lw;
    v.efg = efg; v.elg = elg; v.emen = emen; v.emwe = emwe; v.elerr = elerr;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_rsp(input string nm);
    rsp_t r;
    check({nm, ".f_rvalid"}, 32'(bus.f_rvalid), 32'(sb.size() > 0));
    if (sb.size() > 0) begin
      r = sb.pop_front();
      if (bus.f_rvalid) begin
        check({nm, ".f_rdata"}, bus.f_rdata, r.data);
        check({nm, ".f_err"}, 32'(bus.f_err), 32'(r.err));
      end
      exp_hold = r.data;
    end else if (!bus.f_rvalid) begin
      check({nm, ".f_rdata_hold"}, bus.f_rdata, exp_hold);
    end
  endtask

  task automatic check_zero(input string nm);
    check({nm, ".f_gnt"},    32'(bus.f_gnt),    32'h0);
    check({nm, ".l_gnt"},    32'(bus.l_gnt),    32'h0);
    check({nm, ".f_rvalid"}, 32'(bus.f_rvalid), 32'h0);
    check({nm, ".f_rdata"},  bus.f_rdata,       32'h0);
    check({nm, ".f_err"},    32'(bus.f_err),    32'h0);
    check({nm, ".l_err"},    32'(bus.l_err),    32'h0);
    check({nm, ".l_cnt"},    32'(bus.l_cnt),    32'h0);
    check({nm, ".m_en"},     32'(bus.m_en),     32'h0);
    check({nm, ".m_we"},     32'(bus.m_we),     32'h0);
    check({nm, ".m_idx"},    32'(bus.m_idx),    32'h0);
    check({nm, ".m_wdata"},  bus.m_wdata,       32'h0);
  endtask

  // Called at posedge+1; returns at the next posedge+1.
  task automatic step(input vec_t v);
    logic [31:0]      src;
    logic [IDX_W-1:0] ei;
    rsp_t             r;
    bus.f_req = v.fr; bus.l_req = v.lr; bus.l_lock = v.lk;
    bus.f_addr = v.fa; bus.l_addr = v.la; bus.l_wdata = v.lw;
    @(negedge clk);
    check_rsp(v.name);
    check({v.name, ".l_cnt"}, 32'(bus.l_cnt), 32'(cnt_model));
    check({v.name, ".f_gnt"}, 32'(bus.f_gnt), 32'(v.efg));
    check({v.name, ".l_gnt"}, 32'(bus.l_gnt), 32'(v.elg));
    check({v.name, ".m_en"},  32'(bus.m_en),  32'(v.emen));
    check({v.name, ".m_we"},  32'(bus.m_we),  32'(v.emwe));
    check({v.name, ".l_err"}, 32'(bus.l_err), 32'(v.elerr));
    src = v.efg ? v.fa : v.la;
    ei  = v.emen ? src[IDX_W+1:2] : '0;
    if (v.emen || !(v.efg || v.elg)) begin
      check({v.name, ".m_idx"},   32'(bus.m_idx), 32'(ei));
      check({v.name, ".m_wdata"}, bus.m_wdata, v.emwe ? v.lw : 32'h0);
    end
    if (v.efg) begin
      r.err  = !v.emen;
      r.data = v.emen ? ref_mem[v.fa[IDX_W+1:2]] : 32'h0;
      sb.push_back(r);
    end
    if (v.elg && v.emwe) begin
      ref_mem[v.la[IDX_W+1:2]] = v.lw;
      if (cnt_model != 16'hFFFF) cnt_model = cnt_model + 16'd1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = 32'h0;
      ref_mem[i] = 32'h0;
    end
    mem[0] = 32'h13;  mem[1] = 32'h93;  mem[2] = 32'h113;  mem[3] = 32'h193;
    ref_mem[0] = 32'h13; ref_mem[1] = 32'h93; ref_mem[2] = 32'h113; ref_mem[3] = 32'h193;
    bus.m_rdata = 32'h0;
    bus.f_req = 1'b1; bus.l_req = 1'b1; bus.l_lock = 1'b0;
    bus.f_addr = 32'h0; bus.l_addr = 32'h0; bus.l_wdata = 32'h0;

    //                 name        fr  lr  lk  fa            la            lw             efg elg men mwe lerr
    tbl.push_back(mk("cont1",     1,  1,  0,  32'h0,        32'h100,      32'hA0,        1,  0,  1,  0,  0));
    tbl.push_back(mk("cont2",     1,  1,  0,  32'h4,        32'h100,      32'hA0,        0,  1,  1,  1,  0));
    tbl.push_back(mk("cont3",     1,  1,  0,  32'h4,        32'h104,      32'hA1,        1,  0,  1,  0,  0));
    tbl.push_back(mk("cont4",     1,  1,  0,  32'h8,        32'h104,      32'hA1,        0,  1,  1,  1,  0));
    tbl.push_back(mk("cont5",     1,  1,  0,  32'h8,        32'h108,      32'hA2,        1,  0,  1,  0,  0));
    tbl.push_back(mk("cont6",     1,  1,  0,  32'hC,        32'h108,      32'hA2,        0,  1,  1,  1,  0));
    tbl.push_back(mk("fonly_c",   1,  0,  0,  32'hC,        32'h0,        32'h0,         1,  0,  1,  0,  0));
    tbl.push_back(mk("fonly_0",   1,  0,  0,  32'h0,        32'h0,        32'h0,         1,  0,  1,  0,  0));
    tbl.push_back(mk("fonly_4",   1,  0,  0,  32'h4,        32'h0,        32'h0,         1,  0,  1,  0,  0));
    tbl.push_back(mk("fonly_8",   1,  0,  0,  32'h8,        32'h0,        32'h0,         1,  0,  1,  0,  0));
    tbl.push_back(mk("raw_wr",    0,  1,  0,  32'h0,        32'h40,       32'hDEADBEEF,  0,  1,  1,  1,  0));
    tbl.push_back(mk("raw_rd",    1,  0,  0,  32'h40,       32'h0,        32'h0,         1,  0,  1,  0,  0));
    tbl.push_back(mk("l_only",    0,  1,  0,  32'h0,        32'h44,       32'h55,        0,  1,  1,  1,  0));
    tbl.push_back(mk("lock1",     1,  1,  1,  32'h10,       32'h80,       32'hB0,        0,  1,  1,  1,  0));
    tbl.push_back(mk("lock2",     1,  1,  1,  32'h10,       32'h84,       32'hB1,        0,  1,  1,  1,  0));
    tbl.push_back(mk("lock3",     1,  1,  1,  32'h10,       32'h88,       32'hB2,        0,  1,  1,  1,  0));
    tbl.push_back(mk("lock4",     1,  1,  1,  32'h10,       32'h8C,       32'hB3,        0,  1,  1,  1,  0));
    tbl.push_back(mk("unlock_f",  1,  1,  0,  32'h10,       32'h90,       32'hC0,        1,  0,  1,  0,  0));
    tbl.push_back(mk("unlock_l",  1,  1,  0,  32'h14,       32'h90,       32'hC0,        0,  1,  1,  1,  0));
    tbl.push_back(mk("lock_noreq",1,  0,  1,  32'h14,       32'h0,        32'h0,         0,  0,  0,  0,  0));
    tbl.push_back(mk("f_after",   1,  0,  0,  32'h14,       32'h0,        32'h0,         1,  0,  1,  0,  0));
    tbl.push_back(mk("f_misal",   1,  0,  0,  32'h2,        32'h0,        32'h0,         1,  0,  0,  0,  0));
    tbl.push_back(mk("l_range",   0,  1,  0,  32'h0,        32'h40000,    32'h77,        0,  1,  0,  0,  1));
    tbl.push_back(mk("f_range",   1,  0,  0,  32'h40000,    32'h0,        32'h0,         1,  0,  0,  0,  0));
    tbl.push_back(mk("l_misal",   0,  1,  0,  32'h0,        32'h41,       32'h78,        0,  1,  0,  0,  1));
    tbl.push_back(mk("f_rd_90",   1,  0,  0,  32'h90,       32'h0,        32'h0,         1,  0,  1,  0,  0));
    tbl.push_back(mk("idle",      0,  0,  0,  32'h0,        32'h0,        32'h0,         0,  0,  0,  0,  0));
    tbl.push_back(mk("idle2",     0,  0,  0,  32'h0,        32'h0,        32'h0,         0,  0,  0,  0,  0));

    #12;
    check_zero("reset");
    bus.f_req = 1'b0; bus.l_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (tbl[i]) step(tbl[i]);

    // Reset asserted in the response cycle of a fetch: response is dropped, counter clears.
    step(mk("pre_rst_f", 1, 0, 0, 32'h4, 32'h0, 32'h0, 1, 0, 1, 0, 0));
    rst_n = 1'b0;
    bus.f_req = 1'b1; bus.l_req = 1'b1;
    #1;
    check_zero("mid_reset");
    sb.delete();
    cnt_model = 16'h0;
    exp_hold  = 32'h0;
    bus.f_req = 1'b0; bus.l_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(mk("post_idle1", 0, 0, 0, 32'h0, 32'h0,   32'h0,  0, 0, 0, 0, 0));
    step(mk("post_idle2", 0, 0, 0, 32'h0, 32'h0,   32'h0,  0, 0, 0, 0, 0));
    step(mk("post_cont_f",1, 1, 0, 32'h4, 32'h200, 32'hE1, 1, 0, 1, 0, 0));
    step(mk("post_cont_l",0, 1, 0, 32'h0, 32'h200, 32'hE1, 0, 1, 1, 1, 0));
    step(mk("post_rd",    1, 0, 0, 32'h200, 32'h0, 32'h0,  1, 0, 1, 0, 0));
    step(mk("post_idle3", 0, 0, 0, 32'h0, 32'h0,   32'h0,  0, 0, 0, 0, 0));

    check("sb_drained", 32'(sb.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
